// File: rtl/vc_wrr_pop_scheduler.sv
// vc_wrr_pop_scheduler: weighted round-robin pop scheduler for VC0/VC1 FIFOs feeding D0/D1
// Build option: define STRICT_PRIO_EN to make VC0 strictly higher priority than VC1 (weights ignored).
// Ports:
//   clk, reset_L           clock, synchronous active-low reset
//   D0_full, D1_full       destination FIFO full flags (either one stalls all pops)
//   VC0_empty, VC1_empty   source FIFO empty flags
//   VC0_rd, VC1_rd         combinational pop strobes, at most one high per cycle
//   vc0_delay              registered; 1 = data presented this cycle came from VC1
//   data_valid             registered; a pop was issued the previous cycle
//   pop_cnt_vc0/1          wrapping per-VC pop statistics
module vc_wrr_pop_scheduler #(
   parameter int VC0_WEIGHT = 4,
   parameter int VC1_WEIGHT = 1,
   parameter int CNT_W      = 4,
   parameter int STAT_W     = 16
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              D0_full,
   input  logic              D1_full,
   input  logic              VC0_empty,
   input  logic              VC1_empty,
   output logic              VC0_rd,
   output logic              VC1_rd,
   output logic              vc0_delay,
   output logic              data_valid,
   output logic [STAT_W-1:0] pop_cnt_vc0,
   output logic [STAT_W-1:0] pop_cnt_vc1
);
   typedef enum logic [1:0] {IDLE, SRV0, SRV1} state_t;
   localparam logic [CNT_W-1:0] W0 = CNT_W'(VC0_WEIGHT);
   localparam logic [CNT_W-1:0] W1 = CNT_W'(VC1_WEIGHT);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall, e0, e1, pick0, pick1;
   assign stall = D0_full | D1_full;
   assign e0    = !VC0_empty;
   assign e1    = !VC1_empty;
`ifdef STRICT_PRIO_EN
   assign pick0 = e0;
   assign pick1 = !e0 & e1;
`else
   logic cont0, cont1;
   // keep serving the current VC while under its weight, or when the other VC has nothing
   assign cont0 = e0 & ((cnt_q < W0) | !e1);
   assign cont1 = e1 & ((cnt_q < W1) | !e0);
   assign pick0 = (state_q == SRV0) ? cont0 : (state_q == SRV1) ? (!cont1 & e0) : e0;
   assign pick1 = (state_q == SRV0) ? (!cont0 & e1) : (state_q == SRV1) ? cont1 : (!e0 & e1);
`endif
   assign VC0_rd = reset_L & !stall & pick0;
   assign VC1_rd = reset_L & !stall & pick1;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (VC0_rd) begin
         state_d = SRV0;
         cnt_d   = (state_q != SRV0) ? CNT_W'(1) : (cnt_q >= W0) ? W0 : cnt_q + CNT_W'(1);
      end else if (VC1_rd) begin
         state_d = SRV1;
         cnt_d   = (state_q != SRV1) ? CNT_W'(1) : (cnt_q >= W1) ? W1 : cnt_q + CNT_W'(1);
      end else if (!stall) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         vc0_delay   <= 1'b0;
         data_valid  <= 1'b0;
         pop_cnt_vc0 <= '0;
         pop_cnt_vc1 <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_valid  <= VC0_rd | VC1_rd;
         if (VC0_rd | VC1_rd) vc0_delay <= VC1_rd;
         pop_cnt_vc0 <= pop_cnt_vc0 + STAT_W'(VC0_rd);
         pop_cnt_vc1 <= pop_cnt_vc1 + STAT_W'(VC1_rd);
      end
   end
endmodule
